alu_op_sequencer: RTL and testbench

Multi-cycle sequencer that owns the shared 32-bit ALU and runs 32- or 64-bit operations on it, one word per cycle. For 64-bit ops it chains the carry from the low word into the high word (ADD->ADC, SUB->SBC). Requests arrive over a valid/ready handshake, results leave over a valid/ready handshake, and a 4-bit status register {N,Z,C,V} is updated on flag-setting ops. It sits between the execute-stage issue logic and the ALU instance; the ALU itself stays purely combinational.

---
 rtl/alu_op_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences 32- or 64-bit operations onto a shared combinational 32-bit ALU,
// one word per cycle, with carry chaining and an architectural {N,Z,C,V} register.
module alu_op_sequencer #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_wide,
    input  logic            req_s,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    output logic [DW-1:0]   alu_in1,
    output logic [DW-1:0]   alu_in2,
    output logic            alu_carry,
    output logic [3:0]      alu_cmd,
    input  logic [DW-1:0]   alu_out,
    input  logic [3:0]      alu_status,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_result,
    output logic [3:0]      rsp_flags,
    output logic            rsp_err,
    output logic [3:0]      sr
);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_ILL = 3'b111;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               wide_q, wide_d;
    logic               s_q, s_d;
    logic [2*DW-1:0]    a_q, a_d;
    logic [2*DW-1:0]    b_q, b_d;
    logic [DW-1:0]      res_lo_q, res_lo_d;
    logic [DW-1:0]      res_hi_q, res_hi_d;
    logic [3:0]         flags_lo_q, flags_lo_d;
    logic [3:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic [3:0]         sr_q, sr_d;
    logic [3:0]         lo_cmd;

    always_comb begin
        lo_cmd = 4'b0000;
        case (op_q)
            3'b000:  lo_cmd = 4'b0001;
            3'b001:  lo_cmd = 4'b1001;
            3'b010:  lo_cmd = 4'b0010;
            3'b011:  lo_cmd = 4'b0100;
            3'b100:  lo_cmd = 4'b0110;
            3'b101:  lo_cmd = 4'b0111;
            3'b110:  lo_cmd = 4'b1000;
            default: lo_cmd = 4'b0000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wide_d     = wide_q;
        s_d        = s_q;
        a_d        = a_q;
        b_d        = b_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        flags_lo_d = flags_lo_q;
        flags_d    = flags_q;
        err_d      = err_q;
        sr_d       = sr_q;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_carry  = 1'b0;
        alu_cmd    = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    wide_d = req_wide;
                    s_d    = req_s;
                    a_d    = req_a;
                    b_d    = req_b;
                    // High word is cleared up front so narrow results read back zero-extended.
                    res_lo_d = '0;
                    res_hi_d = '0;
                    if (req_op == OP_ILL) begin
                        flags_d = 4'b0000;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                alu_in1    = a_q[DW-1:0];
                alu_in2    = b_q[DW-1:0];
                alu_cmd    = lo_cmd;
                res_lo_d   = alu_out;
                flags_lo_d = alu_status;
                flags_d    = alu_status;
                state_d    = wide_q ? ST_HI : ST_DONE;
            end
            ST_HI: begin
                alu_in1 = a_q[2*DW-1:DW];
                alu_in2 = b_q[2*DW-1:DW];
                alu_cmd = lo_cmd;
                // ALU reports borrow on subtract, while SBC consumes an inverted carry.
                if (op_q == OP_ADD) begin
                    alu_cmd   = 4'b0011;
                    alu_carry = flags_lo_q[1];
                end else if (op_q == OP_SUB) begin
                    alu_cmd   = 4'b0101;
                    alu_carry = ~flags_lo_q[1];
                end
                res_hi_d = alu_out;
                flags_d  = {alu_status[3], alu_status[2] & flags_lo_q[2], alu_status[1:0]};
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    if (s_q && !err_q) begin
                        sr_d = flags_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            wide_q     <= 1'b0;
            s_q        <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            flags_lo_q <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            sr_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wide_q     <= wide_d;
            s_q        <= s_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            flags_lo_q <= flags_lo_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
            sr_q       <= sr_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_result = {res_hi_q, res_lo_q};
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign sr         = sr_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural 32-bit ALU, a 64-bit reference model
// and a response scoreboard.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_wide;
    logic        req_s;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        alu_carry;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_out;
    logic [3:0]  alu_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [3:0]  sr;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_wide(req_wide), .req_s(req_s), .req_a(req_a), .req_b(req_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry(alu_carry), .alu_cmd(alu_cmd),
        .alu_out(alu_out), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .sr(sr)
    );

    // Combinational ALU: C is carry-out on add, borrow on subtract; SBC subtracts !carry.
    always_comb begin
        logic [32:0] t;
        logic        c;
        logic        v;
        t = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_cmd)
            4'b0001: t = {1'b0, alu_in2};
            4'b1001: t = {1'b0, ~alu_in2};
            4'b0010, 4'b0011: begin
                t = {1'b0, alu_in1} + {1'b0, alu_in2} + ((alu_cmd == 4'b0011) ? {32'd0, alu_carry} : 33'd0);
                c = t[32];
                v = (alu_in1[31] == alu_in2[31]) && (t[31] != alu_in1[31]);
            end
            4'b0100, 4'b0101: begin
                t = {1'b0, alu_in1} - {1'b0, alu_in2} - ((alu_cmd == 4'b0101) ? {32'd0, ~alu_carry} : 33'd0);
                c = t[32];
                v = (alu_in1[31] != alu_in2[31]) && (t[31] != alu_in1[31]);
            end
            4'b0110: t = {1'b0, alu_in1 & alu_in2};
            4'b0111: t = {1'b0, alu_in1 | alu_in2};
            4'b1000: t = {1'b0, alu_in1 ^ alu_in2};
            default: t = '0;
        endcase
        alu_out    = t[31:0];
        alu_status = {t[31], (t[31:0] == 32'd0), c, v};
    end

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  sr_exp = 4'b0000;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full-width reference: flags computed over the whole 32- or 64-bit operation.
    function automatic exp_t model(input logic [2:0] op, input logic wide,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [64:0] t;
        logic [63:0] m, aa, bb, r;
        int          sb;
        logic        c, v;
        m  = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sb = wide ? 63 : 31;
        aa = a & m;
        bb = b & m;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: r = bb;
            3'd1: r = ~bb & m;
            3'd2: begin
                t = {1'b0, aa} + {1'b0, bb};
                r = t[63:0] & m;
                c = wide ? t[64] : t[32];
                v = (aa[sb] == bb[sb]) && (r[sb] != aa[sb]);
            end
            3'd3: begin
                r = (aa - bb) & m;
                c = (aa < bb);
                v = (aa[sb] != bb[sb]) && (r[sb] != aa[sb]);
            end
            3'd4: r = aa & bb;
            3'd5: r = aa | bb;
            3'd6: r = aa ^ bb;
            default: r = '0;
        endcase
        e.res   = r;
        e.flags = {r[sb], (r == 64'd0), c, v};
        e.err   = 1'b0;
        if (op == 3'd7) begin
            e.res   = '0;
            e.flags = '0;
            e.err   = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [3:0] cmd_of(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b1001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b0111;
            3'd6:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_depth", 64'(sb_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("rsp_result", rsp_result, e.res);
                check_val("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                check_val("rsp_err", 64'(rsp_err), 64'(e.err));
                $display("rsp result=%h flags=%b err=%b", rsp_result, rsp_flags, rsp_err);
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic wide, input logic s,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        exp_t        e;
        int          lat, exp_lat;
        logic [32:0] lo_sum;
        logic [3:0]  hi_cmd;
        logic        hi_carry;
        e       = model(op, wide, a, b);
        exp_lat = (op == 3'd7) ? 1 : (wide ? 3 : 2);
        lo_sum  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        hi_cmd   = cmd_of(op);
        hi_carry = 1'b0;
        if (op == 3'd2) begin hi_cmd = 4'b0011; hi_carry = lo_sum[32]; end
        if (op == 3'd3) begin hi_cmd = 4'b0101; hi_carry = (a[31:0] >= b[31:0]); end

        @(negedge clk);
        check_val("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_wide  = wide;
        req_s     = s;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        // Scramble the request bus: only the accept edge may matter.
        req_valid = (hold > 0);
        req_op    = 3'($urandom);
        req_wide  = 1'($urandom);
        req_s     = 1'($urandom);
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            if (lat == 1) begin
                check_val("lo_in1", 64'(alu_in1), 64'(a[31:0]));
                check_val("lo_in2", 64'(alu_in2), 64'(b[31:0]));
                check_val("lo_cmd", 64'(alu_cmd), 64'(cmd_of(op)));
                check_val("lo_carry", 64'(alu_carry), 64'd0);
            end
            if (lat == 2) begin
                check_val("hi_in1", 64'(alu_in1), 64'(a[63:32]));
                check_val("hi_cmd", 64'(alu_cmd), 64'(hi_cmd));
                check_val("hi_carry", 64'(alu_carry), 64'(hi_carry));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", 64'(lat), 64'(exp_lat));
        check_val("done_cmd", 64'(alu_cmd), 64'd0);
        for (int i = 0; i < hold; i++) begin
            check_val("hold_result", rsp_result, e.res);
            check_val("hold_flags", 64'(rsp_flags), 64'(e.flags));
            check_val("hold_req_ready", 64'(req_ready), 64'd0);
            check_val("hold_valid", 64'(rsp_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        if (s && op != 3'd7) sr_exp = e.flags;
        check_val("idle_after", 64'(req_ready), 64'd1);
        check_val("valid_after", 64'(rsp_valid), 64'd0);
        check_val("sr", 64'(sr), 64'(sr_exp));
        $display("op=%0d wide=%0d s=%0d a=%h b=%h lat=%0d sr=%b", op, wide, s, a, b, lat, sr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_wide  = 1'b0;
        req_s     = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_sr", 64'(sr), 64'd0);
        check_val("rst_result", rsp_result, 64'd0);
        check_val("rst_cmd", 64'(alu_cmd), 64'd0);

        run_op(3'd2, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 0);
        run_op(3'd3, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'h1, 0);
        run_op(3'd2, 1'b0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'h1, 0);
        run_op(3'd6, 1'b1, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678, 0);
        run_op(3'd1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0000_FFFF_0000_FFFF, 5);
        run_op(3'd7, 1'b1, 1'b1, 64'h1234, 64'h5678, 0);
        run_op(3'd3, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'h1, 0);
        for (int i = 0; i < 20; i++) begin
            run_op(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, (i % 5 == 0) ? 2 : 0);
        end
        run_op(3'd2, 1'b0, 1'b1, 64'h0, 64'h0, 0);
        run_op(3'd0, 1'b1, 1'b1, 64'h0, 64'h8000_0000_0000_0001, 0);

        // Reset during the HI cycle of a wide ADD discards the op.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_wide  = 1'b1;
        req_s     = 1'b1;
        req_a     = 64'h0000_0000_FFFF_FFFF;
        req_b     = 64'h1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_hi_cmd", 64'(alu_cmd), 64'h3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        sr_exp = 4'b0000;
        check_val("mrst_req_ready", 64'(req_ready), 64'd1);
        check_val("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("mrst_sr", 64'(sr), 64'd0);
        check_val("mrst_cmd", 64'(alu_cmd), 64'd0);
        check_val("mrst_result", rsp_result, 64'd0);
        check_val("mrst_flags", 64'(rsp_flags), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        run_op(3'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);

        @(negedge clk);
        check_val("sb_final", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
